// File: rtl/latch_snapshot_streamer.sv
// latch_snapshot_streamer: freezes pipeline latch words and streams them as a framed, checksummed byte stream
module latch_snapshot_streamer #(
  parameter int NUM_WORDS = 16,
  parameter int DATA_W = 32,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_WORDS*DATA_W-1:0] in_snapshot,
  input  logic                        capture,
  input  logic                        mode,
  input  logic                        abort,
  input  logic                        tx_ready,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 frame_count,
  output logic [7:0]                  overrun_count
);
  localparam int NB = NUM_WORDS * DATA_W / 8;
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NB - 1);
  typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, DONE} state_t;
  state_t state, state_nxt;
  logic [NB-1:0][7:0] buffer, buf_nxt;
  logic [IW-1:0] byte_idx, idx_nxt;
  logic [7:0] checksum, chk_nxt, data_nxt;
  logic hs, load, step, overrun;
  assign hs = tx_valid && tx_ready;
  assign load = !abort && ((state == IDLE && capture) || (state == DONE && mode));
  assign step = !abort && hs && state == DATA;
  assign overrun = capture && state != IDLE && !(state == DONE && mode);
  always_comb begin
    state_nxt = abort ? IDLE :
                state == IDLE ? (capture ? HDR : IDLE) :
                state == HDR ? (hs ? DATA : HDR) :
                state == DATA ? (hs && byte_idx == LAST ? CHK : DATA) :
                state == CHK ? (hs ? DONE : CHK) :
                mode ? HDR : IDLE;
    buf_nxt = load ? in_snapshot : buffer;
    idx_nxt = load ? '0 : step ? byte_idx + IW'(1) : byte_idx;
    chk_nxt = load ? 8'h00 : step ? checksum ^ buffer[byte_idx] : checksum;
    data_nxt = state_nxt == HDR ? HEADER :
               state_nxt == DATA ? buf_nxt[idx_nxt] :
               state_nxt == CHK ? chk_nxt : 8'h00;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      buffer <= '0;
      byte_idx <= '0;
      checksum <= 8'h00;
      tx_data <= 8'h00;
      tx_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      frame_count <= 16'h0000;
      overrun_count <= 8'h00;
    end else begin
      state <= state_nxt;
      buffer <= buf_nxt;
      byte_idx <= idx_nxt;
      checksum <= chk_nxt;
      tx_data <= data_nxt;
      tx_valid <= state_nxt == HDR || state_nxt == DATA || state_nxt == CHK;
      busy <= state_nxt != IDLE;
      done <= state_nxt == DONE;
      if (state_nxt == DONE) frame_count <= frame_count + 16'd1;
      if (overrun && overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
    end
endmodule

// File: tb/tb_latch_snapshot_streamer.sv
// tb_latch_snapshot_streamer: directed checks of framing, stalls, overruns, abort, auto-rearm and async reset
module tb_latch_snapshot_streamer;
  localparam logic [63:0] WORDS = 64'hAABBCCDD_11223344;
  logic clk = 0, rst = 1, capture = 0, mode = 0, abort = 0, tx_ready = 0;
  logic [63:0] in_snapshot = '0;
  logic [7:0] tx_data, overrun_count;
  logic tx_valid, busy, done;
  logic [15:0] frame_count;
  int checks = 0, errors = 0, nbytes, stall_bad, exp_fc = 0;
  logic [7:0] got [16];
  logic [7:0] exp_frame [10] = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44};
  latch_snapshot_streamer #(.NUM_WORDS(2), .DATA_W(32), .HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst), .in_snapshot(in_snapshot), .capture(capture), .mode(mode),
    .abort(abort), .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .busy(busy), .done(done), .frame_count(frame_count), .overrun_count(overrun_count)
  );
  always #5 clk = ~clk;
  task automatic collect(input bit toggle, input bit scramble, input int pulses);
    bit rdy, stall;
    logic [7:0] held;
    nbytes = 0;
    stall_bad = 0;
    stall = 0;
    rdy = 0;
    held = 0;
    for (int c = 0; c < 200 && nbytes < 10; c++) begin
      @(negedge clk);
      capture = c >= 2 && c < 2 + 2 * pulses && c % 2 == 0;
      if (scramble) in_snapshot = {$urandom, $urandom};
      if (stall && tx_data !== held) stall_bad++;
      rdy = toggle ? !rdy : 1'b1;
      tx_ready = rdy;
      if (tx_valid && rdy) begin
        got[nbytes] = tx_data;
        nbytes++;
      end
      stall = tx_valid && !rdy;
      held = tx_data;
    end
    capture = 0;
  endtask
  task automatic test_reset();
    #1;
    checks++;
    if ({tx_valid, tx_data, busy, done, frame_count, overrun_count} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {tx_valid, tx_data, busy, done, frame_count, overrun_count});
    end
    @(negedge clk);
    rst = 0;
  endtask
  task automatic test_basic();
    @(negedge clk);
    in_snapshot = WORDS;
    capture = 1;
    tx_ready = 1;
    collect(0, 0, 0);
    checks++;
    if (nbytes != 10) begin errors++; $display("FAIL basic_count got %0d exp 10", nbytes); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got[i] !== exp_frame[i]) begin errors++; $display("FAIL basic_byte%0d got %h exp %h", i, got[i], exp_frame[i]); end
    end
    @(negedge clk);
    exp_fc++;
    checks++;
    if ({done, tx_valid, frame_count} !== {2'b10, 16'(exp_fc)}) begin
      errors++;
      $display("FAIL basic_done got done=%b valid=%b fc=%0d exp done=1 valid=0 fc=%0d", done, tx_valid, frame_count, exp_fc);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, tx_valid} !== 3'b000) begin
      errors++;
      $display("FAIL basic_after got done=%b busy=%b valid=%b exp 000", done, busy, tx_valid);
    end
  endtask
  task automatic test_stall();
    @(negedge clk);
    in_snapshot = WORDS;
    capture = 1;
    collect(1, 1, 0);
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL stall_stable got %0d changes exp 0", stall_bad); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got[i] !== exp_frame[i]) begin errors++; $display("FAIL stall_byte%0d got %h exp %h", i, got[i], exp_frame[i]); end
    end
    @(negedge clk);
    exp_fc++;
    checks++;
    if ({done, frame_count} !== {1'b1, 16'(exp_fc)}) begin
      errors++;
      $display("FAIL stall_done got done=%b fc=%0d exp done=1 fc=%0d", done, frame_count, exp_fc);
    end
    @(negedge clk);
  endtask
  task automatic test_overrun();
    @(negedge clk);
    in_snapshot = WORDS;
    capture = 1;
    tx_ready = 1;
    collect(0, 0, 3);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got[i] !== exp_frame[i]) begin errors++; $display("FAIL overrun_byte%0d got %h exp %h", i, got[i], exp_frame[i]); end
    end
    @(negedge clk);
    exp_fc++;
    @(negedge clk);
    checks++;
    if ({overrun_count, frame_count} !== {8'd3, 16'(exp_fc)}) begin
      errors++;
      $display("FAIL overrun_three got ovr=%0d fc=%0d exp ovr=3 fc=%0d", overrun_count, frame_count, exp_fc);
    end
    capture = 1;
    tx_ready = 0;
    repeat (300) @(negedge clk);
    capture = 0;
    abort = 1;
    @(negedge clk);
    abort = 0;
    checks++;
    if ({overrun_count, tx_valid} !== {8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL overrun_sat got ovr=%h valid=%b exp ovr=ff valid=0", overrun_count, tx_valid);
    end
  endtask
  task automatic test_abort();
    @(negedge clk);
    in_snapshot = WORDS;
    capture = 1;
    tx_ready = 1;
    @(negedge clk);
    capture = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (tx_data !== 8'h11) begin errors++; $display("FAIL abort_4th got %h exp 11", tx_data); end
    abort = 1;
    @(negedge clk);
    abort = 0;
    checks++;
    if ({tx_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL abort_idle got valid=%b busy=%b done=%b exp 000", tx_valid, busy, done);
    end
    @(negedge clk);
    checks++;
    if ({done, frame_count} !== {1'b0, 16'(exp_fc)}) begin
      errors++;
      $display("FAIL abort_nodone got done=%b fc=%0d exp done=0 fc=%0d", done, frame_count, exp_fc);
    end
    capture = 1;
    collect(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got[i] !== exp_frame[i]) begin errors++; $display("FAIL abort_retry_byte%0d got %h exp %h", i, got[i], exp_frame[i]); end
    end
    @(negedge clk);
    exp_fc++;
    checks++;
    if ({done, frame_count} !== {1'b1, 16'(exp_fc)}) begin
      errors++;
      $display("FAIL abort_retry_done got done=%b fc=%0d exp done=1 fc=%0d", done, frame_count, exp_fc);
    end
    @(negedge clk);
  endtask
  task automatic test_back_to_back();
    @(negedge clk);
    in_snapshot = WORDS;
    mode = 1;
    capture = 1;
    tx_ready = 1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        capture = 0;
        if (f == 2 && i == 0) mode = 0;
        checks++;
        if ({tx_valid, tx_data} !== {1'b1, exp_frame[i]}) begin
          errors++;
          $display("FAIL rearm_f%0d_byte%0d got valid=%b data=%h exp valid=1 data=%h", f, i, tx_valid, tx_data, exp_frame[i]);
        end
      end
      @(negedge clk);
      exp_fc++;
      checks++;
      if ({done, tx_valid, frame_count} !== {2'b10, 16'(exp_fc)}) begin
        errors++;
        $display("FAIL rearm_done_f%0d got done=%b valid=%b fc=%0d exp done=1 valid=0 fc=%0d", f, done, tx_valid, frame_count, exp_fc);
      end
    end
    @(negedge clk);
    checks++;
    if ({tx_valid, busy, done, frame_count} !== {3'b000, 16'(exp_fc)}) begin
      errors++;
      $display("FAIL rearm_stop got valid=%b busy=%b done=%b fc=%0d exp 000 fc=%0d", tx_valid, busy, done, frame_count, exp_fc);
    end
  endtask
  task automatic test_async_reset();
    @(negedge clk);
    in_snapshot = WORDS;
    capture = 1;
    tx_ready = 1;
    @(negedge clk);
    capture = 0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    exp_fc = 0;
    checks++;
    if ({tx_valid, tx_data, busy, done, frame_count, overrun_count} !== 34'd0) begin
      errors++;
      $display("FAIL async_reset got %h exp 0", {tx_valid, tx_data, busy, done, frame_count, overrun_count});
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    in_snapshot = WORDS;
    capture = 1;
    collect(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got[i] !== exp_frame[i]) begin errors++; $display("FAIL reset_retry_byte%0d got %h exp %h", i, got[i], exp_frame[i]); end
    end
    @(negedge clk);
    exp_fc++;
    checks++;
    if ({done, frame_count} !== {1'b1, 16'(exp_fc)}) begin
      errors++;
      $display("FAIL reset_retry_done got done=%b fc=%0d exp done=1 fc=%0d", done, frame_count, exp_fc);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overrun();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/latch_snapshot_streamer.md
# latch_snapshot_streamer

Parametrised pipeline-state snapshot engine for the MIPS debug path. It supersedes the fixed-width, one-word-at-a-time latch mux: on a capture request it freezes up to NUM_WORDS pipeline latch words in one cycle. It then serialises them as a framed, checksummed byte stream toward the debug UART transmitter over a valid/ready handshake. It sits between the pipeline stage latches (IF/ID/EX/MEM/WB) and the debug unit's TX path.

## Interface
- NUM_WORDS, 16, number of latch words captured per snapshot (≥1)
- DATA_W, 32, width of each latch word; must be a multiple of 8
- HEADER, 8'hA5, frame start byte

- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_snapshot  in  NUM_WORDS*DATA_W  flattened latch words; word i at [i*DATA_W +: DATA_W]
- capture  in  1  snapshot request; sampled every cycle
- mode  in  1  0 = single-shot, 1 = auto-rearm (continuous)
- abort  in  1  synchronous frame abort
- tx_ready  in  1  UART TX can accept a byte
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid
- busy  out  1  frame in progress (any state other than IDLE)
- done  out  1  one-cycle pulse when a frame completes
- frame_count  out  16  completed frames, wraps 16'hFFFF→0
- overrun_count  out  8  captures ignored while busy, saturates at 8'hFF

## Operation
- Frame is the HEADER byte, then the data bytes, then the CHK byte.
- Data bytes run word 0 first, LSB byte first within each word.
- CHK is the XOR of all data bytes. HEADER is excluded from CHK.
- Total bytes per frame = 2 + NUM_WORDS*DATA_W/8.
- States are IDLE, HEADER, DATA, CHECK and DONE.
- IDLE→HEADER: capture=1 and abort=0. All words are registered into the internal buffer on that edge, and the checksum is cleared.
- HEADER→DATA on a handshake.
- DATA stays in DATA while byte_idx < last. It goes to CHECK on the handshake of the last data byte.
- CHECK→DONE on a handshake.
- DONE lasts one cycle, with done=1 and frame_count+1. It then goes to IDLE.
- Auto-rearm: in DONE with mode=1, the buffer is recaptured from in_snapshot on that edge and the next state is HEADER instead of IDLE. In this case capture is not required.
- A handshake is tx_valid && tx_ready. The byte index advances and the checksum accumulates only on a handshake.
- tx_data and tx_valid hold steady while tx_valid && !tx_ready.
- tx_valid=1 exactly in HEADER, DATA and CHECK.
- The buffer is immune to in_snapshot changes after capture.
- capture=1 in any state other than IDLE is ignored and increments overrun_count (saturating). The DONE cycle with mode=1 counts as a recapture, not an overrun.
- abort=1 in any state forces IDLE on the next edge. An abort never produces done and never increments frame_count. abort has priority over capture and over the handshake in the same cycle.
- Simultaneous abort and capture in IDLE: the block stays in IDLE with no capture.

## Timing
- Reset values: state=IDLE, tx_valid=0, tx_data=8'h00, busy=0, done=0, frame_count=0, overrun_count=0, buffer=0, checksum=0.
- Reset mid-frame drops the frame immediately (asynchronous). No partial done is produced.
- Capture latency: capture high at edge N puts tx_valid=1 with tx_data=HEADER after edge N.
- With tx_ready held at 1, a frame occupies 2+NUM_WORDS*DATA_W/8 consecutive cycles of tx_valid. done follows one cycle after the CHK handshake.
- In auto-rearm with tx_ready=1, the gap between frames is exactly one cycle (DONE).
- busy rises with tx_valid. It falls in the cycle after DONE, unless the block rearms.
- Outputs are registered. There is no combinational path from tx_ready to tx_valid or tx_data.

## Test plan
- NUM_WORDS=2, DATA_W=32; words 0x11223344 and 0xAABBCCDD; capture pulse; tx_ready=1.
  - Required bytes: A5 44 33 22 11 DD CC BB AA 44.
  - done is high for one cycle after CHK, frame_count=1, busy=0 afterwards.
- Same words with tx_ready toggling 1-0-1-0.
  - The identical byte sequence is required.
  - tx_data must be stable during every stall cycle.
  - in_snapshot is changed after capture and must not affect the output.
- capture pulsed during the DATA phase, three times.
  - The frame must be unaffected and overrun_count=3.
  - 300 such pulses must leave overrun_count=0xFF.
- abort asserted at the 4th data byte.
  - tx_valid=0 on the next cycle, no done pulse, frame_count unchanged.
  - A new capture must then yield a full, correct frame starting with A5.
- mode=1 with a single capture and tx_ready=1.
  - Back-to-back frames are required, separated by exactly one DONE cycle.
  - frame_count increments per frame.
  - Dropping mode to 0 must end the stream after the current frame.
- rst asserted asynchronously mid-frame, between clock edges.
  - All outputs must go to reset values immediately.
  - The next capture must produce a correct frame.
